spi_master_gen: RTL
===================

Name: spi_master_gen

Overview:
Parametrised full-duplex SPI master, successor to the fixed-mode single-slave master. Adds:
- configurable word length and SCK divider
- runtime CPOL/CPHA mode selection
- multiple active-low slave selects
- start/busy/done handshake

Sits between core-side control logic and external SPI pins, all on one system clock.

Parameters:
DATA_LEN, 8, bits per transfer (2..32), shifted MSB first.
NUM_SS, 1, number of slave-select outputs (1..8).
CLK_DIV, 2, SCK half-period in clk cycles (>=1).
SS_W, (NUM_SS>1 ? $clog2(NUM_SS) : 1), width of ss_sel (localparam).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  request transfer; sampled only when busy=0.
cpol  in  1  SCK idle level; latched at start accept.
cpha  in  1  0: sample on leading edge, 1: sample on trailing edge; latched at start accept.
ss_sel  in  SS_W  slave index; latched at start accept.
tx_data  in  DATA_LEN  word to send; latched at start accept.
rx_data  out  DATA_LEN  last received word; updated only when done pulses.
busy  out  1  high from cycle after accept until done cycle (inclusive of done's falling edge: busy=0 when done=1).
done  out  1  one-cycle pulse at transfer end.
sck  out  1  SPI clock.
mosi  out  1  master data out.
miso  in  1  master data in (assumed synchronous to sck; no synchroniser).
ss_n  out  NUM_SS  active-low slave selects.

Behaviour:
- Reset values: sck=0, mosi=0, ss_n=all 1, busy=0, done=0, rx_data=0, state=IDLE, latched cpol=0.
- Start acceptance:
  - Accepted at the rising edge where start=1, busy=0 and rst=0.
  - start is level-sensitive; holding it high after done launches back-to-back transfers with one IDLE cycle between them.
  - start while busy=1 is ignored and not queued.
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE: sck=latched cpol, ss_n all high, done=0 unless just leaving HOLD.
- SETUP (CLK_DIV cycles):
  - ss_n[ss_sel]=0; busy=1.
  - cpha=0: mosi=first bit. cpha=1: mosi holds previous value.
- XFER:
  - 2*DATA_LEN SCK edges, one every CLK_DIV cycles.
  - Leading edges move sck away from cpol.
  - cpha=0: sample miso on leading edges, drive next bit on trailing edges (none after last).
  - cpha=1: drive bit on leading edges, sample on trailing edges.
  - Receive shift register is left-shift, MSB first.
- HOLD: CLK_DIV cycles; sck=cpol; ss_n still asserted.
- Exit from HOLD:
  - next cycle: state=IDLE, ss_n all high, busy=0, done=1, rx_data=shift register.
- Latency: done is high exactly (2*DATA_LEN+2)*CLK_DIV+1 cycles after the accept edge.
- ss_sel >= NUM_SS: transfer runs normally with all ss_n high; done still pulses.
- Reset mid-transfer: next cycle all outputs at reset values; no done pulse; rx_data cleared.
- Counters:
  - divider width $clog2(CLK_DIV+1)
  - edge counter width $clog2(2*DATA_LEN+1)
  - no wrap within a transfer.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit, latched at start accept). When lsb_first=1, tx_data is shifted out LSB first and received bits fill from MSB toward LSB, so rx_data bit 0 is the first bit received.
- Undefined: port absent; always MSB first.

Decomposition:
- Package spi_pkg holds:
  - state encoding localparams (ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD)
  - SPI mode constants (MODE0..MODE3 as {cpol,cpha}).
- Sub-module spi_sck_gen #(CLK_DIV):
  - inputs clk, rst, run, cpol
  - outputs sck, lead_stb, trail_stb (one-cycle strobes coincident with the SCK edge update)
- The top holds the FSM, shift registers and ss decode.

Test Plan:
- Mode 0, DATA_LEN=8, CLK_DIV=2: start with tx_data=0xA5; slave model returns 0x3C. Required: mosi bits 1,0,1,0,0,1,0,1 on leading edges; rx_data=0x3C; done pulses 37 cycles after accept; 8 rising sck edges.
- Mode 3 (cpol=1, cpha=1), tx_data=0x81, miso=0x7E. Required: sck idles high; rx_data=0x7E; ss_n low for exactly 36 cycles.
- NUM_SS=4, ss_sel=2. Required: ss_n=4'b1011 during transfer and 4'b1111 otherwise. Repeat with ss_sel=3 then ss_n=4'b0111.
- start pulsed again 5 cycles after accept with tx_data=0xFF. Required: ignored; first transfer completes unchanged; exactly one done pulse.
- rst asserted 10 cycles into a transfer. Required: next cycle ss_n all high, busy=0, sck=0, rx_data=0; no done pulse; a subsequent start works normally.
- With SPI_MASTER_LSB_FIRST_EN defined, lsb_first=1, tx_data=0x01. Required: first mosi bit=1, rest 0. Slave sending 1,0,0,0,0,0,0,0 gives rx_data=0x01.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for spi_master_gen: FSM state encoding and SPI mode codes.
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_XFER  = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: toggles sck every CLK_DIV cycles while run=1, parks at cpol otherwise.
// Latency: first edge CLK_DIV cycles after run rises; strobes are valid in the cycle whose closing edge moves sck.
// No backpressure; run is the only control.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic cpol,
  output logic sck,
  output logic lead_stb,
  output logic trail_stb
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  always_comb begin
    tick      = run && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    if (!run) begin
      div_cnt_d = '0;
      sck_d     = cpol;
    end else if (tick) begin
      div_cnt_d = '0;
      sck_d     = ~sck_q;
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  assign sck       = sck_q;
  assign lead_stb  = tick && (sck_q == cpol);
  assign trail_stb = tick && (sck_q != cpol);

endmodule

// File: rtl/spi_master_gen.sv
// Full-duplex SPI master, runtime CPOL/CPHA, NUM_SS selects; SPI_MASTER_LSB_FIRST_EN adds lsb_first.
// Latency: done pulses (2*DATA_LEN+2)*CLK_DIV+1 cycles after start is accepted.
// start is only taken while busy=0; requests during a transfer are dropped, not queued.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int NUM_SS   = 1,
  parameter int CLK_DIV  = 2,
  localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [SS_W-1:0]     ss_sel,
  input  logic [DATA_LEN-1:0] tx_data,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                lsb_first,
`endif
  output logic [DATA_LEN-1:0] rx_data,
  output logic                busy,
  output logic                done,
  output logic                sck,
  output logic                mosi,
  input  logic                miso,
  output logic [NUM_SS-1:0]   ss_n
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int EW = $clog2(2 * DATA_LEN + 1);
  localparam logic [DW-1:0] PH_LAST   = DW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_LEN - 1);

  state_t                state_q, state_d;
  logic [DW-1:0]         ph_cnt_q, ph_cnt_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic [SS_W-1:0]       ss_sel_q, ss_sel_d;
  logic [DATA_LEN-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                  mosi_q, mosi_d, busy_q, busy_d, fin_q, fin_d, done_q, done_d;
  logic [NUM_SS-1:0]     ss_n_q, ss_n_d;
  logic                  accept, lead_stb, trail_stb, last_edge, ph_end;
  logic                  samp_on_lead, sample_ev, drive_ev, lsb_in, lsb_mode;

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_first_q;
  always_ff @(posedge clk) begin
    if (rst)         lsb_first_q <= 1'b0;
    else if (accept) lsb_first_q <= lsb_first;
  end
  assign lsb_in   = lsb_first;
  assign lsb_mode = lsb_first_q;
`else
  assign lsb_in   = 1'b0;
  assign lsb_mode = 1'b0;
`endif

  assign accept    = start && !busy_q;
  assign last_edge = trail_stb && (edge_cnt_q == EDGE_LAST);
  assign ph_end    = (ph_cnt_q == PH_LAST);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q == ST_XFER),
    .cpol     (cpol_q),
    .sck      (sck),
    .lead_stb (lead_stb),
    .trail_stb(trail_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_SETUP;
      ST_SETUP: if (ph_end)    state_d = ST_XFER;
      ST_XFER:  if (last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (ph_end)    state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Pin-side controls trail the state by one cycle; fin_q bridges HOLD exit to the done cycle.
  always_comb begin
    ss_n_d = '1;
    if (state_q != ST_IDLE) begin
      for (int i = 0; i < NUM_SS; i++) begin
        if (ss_sel_q == SS_W'(i)) ss_n_d[i] = 1'b0;
      end
    end
    fin_d  = (state_q == ST_HOLD) && ph_end;
    done_d = fin_q;
    busy_d = accept || (busy_q && !fin_q);
  end

  always_comb begin
    ph_cnt_d   = '0;
    if ((state_q == ST_SETUP || state_q == ST_HOLD) && !ph_end) ph_cnt_d = ph_cnt_q + DW'(1);
    edge_cnt_d = edge_cnt_q;
    if (accept)                    edge_cnt_d = '0;
    else if (lead_stb || trail_stb) edge_cnt_d = edge_cnt_q + EW'(1);

    samp_on_lead = 1'b1;
    unique case ({cpol_q, cpha_q})
      MODE0, MODE2: samp_on_lead = 1'b1;
      MODE1, MODE3: samp_on_lead = 1'b0;
    endcase
    sample_ev = samp_on_lead ? lead_stb : trail_stb;
    drive_ev  = samp_on_lead ? (trail_stb && !last_edge) : lead_stb;

    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    ss_sel_d  = ss_sel_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    mosi_d    = mosi_q;
    rx_data_d = fin_q ? rx_sh_q : rx_data_q;
    if (accept) begin
      cpol_d   = cpol;
      cpha_d   = cpha;
      ss_sel_d = ss_sel;
      rx_sh_d  = '0;
      tx_sh_d  = tx_data;
      // cpha=0 puts the first bit on mosi before the first leading edge
      if (!cpha) begin
        mosi_d  = lsb_in ? tx_data[0] : tx_data[DATA_LEN-1];
        tx_sh_d = lsb_in ? (tx_data >> 1) : (tx_data << 1);
      end
    end else begin
      if (drive_ev) begin
        mosi_d  = lsb_mode ? tx_sh_q[0] : tx_sh_q[DATA_LEN-1];
        tx_sh_d = lsb_mode ? (tx_sh_q >> 1) : (tx_sh_q << 1);
      end
      if (sample_ev) begin
        rx_sh_d = lsb_mode ? {miso, rx_sh_q[DATA_LEN-1:1]} : {rx_sh_q[DATA_LEN-2:0], miso};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt_q   <= '0;
      edge_cnt_q <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      ss_sel_q   <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ph_cnt_q   <= ph_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      ss_sel_q   <= ss_sel_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      done_q     <= done_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule
